instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch-side partner of the PC block. It consumes the PC block's word address `pc`, 32-bit `pc_reg` and `pc_sel` each cycle, and drives a 1-cycle-latency synchronous instruction SRAM. It presents the returned instruction, with its PC and a valid flag, to the decode stage. It holds the instruction across stalls, squashes the wrong-path fetch after a redirect, and keeps a fetch counter.

## Interface
Parameters:
- `NOP`, 32'h0000_0013, instruction word driven on bubbles (addi x0,x0,0).
- `AW`, 14, SRAM word-address width; must match `pc` width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_sel`  in  2  PC update select for this cycle: 00 sequential, 01 redirect, 10 hold, 11 treated as hold.
- `pc`  in  AW  word address currently held by the PC block (`pc_reg[15:2]`).
- `pc_reg`  in  32  byte PC currently held by the PC block.
- `im_ceb`  out  1  SRAM chip enable, active-low.
- `im_a`  out  AW  SRAM word address.
- `im_do`  in  32  SRAM read data; valid the cycle after the address.
- `inst`  out  32  instruction to decode.
- `inst_valid`  out  1  `inst` is a real instruction, not a bubble.
- `inst_pc`  out  32  byte PC of `inst`.
- `fetch_cnt`  out  16  count of newly delivered valid instructions.

## Operation
- SRAM read path:
  - `im_a = pc` combinationally.
  - `im_ceb = ~rst_n`, so a read is issued every cycle out of reset, including during stalls. The SRAM holds no state for this block.
- Registered state:
  - `state` ∈ {BOOT, RUN, STALL, FLUSH}.
  - `hold_inst`[31:0], `hold_valid`, `inst_pc`[31:0], `fetch_cnt`[15:0].
- Outputs by state:
  - BOOT: `inst=NOP`, `inst_valid=0`.
  - RUN: `inst=im_do`, `inst_valid=1`.
  - STALL: `inst=hold_inst`, `inst_valid=hold_valid`.
  - FLUSH: `inst=NOP`, `inst_valid=0`.
- Transitions are evaluated at every clock edge on `pc_sel`, with the same rules from every state:
  - 00 → RUN; `inst_pc <= pc_reg`.
  - 01 → FLUSH; `inst_pc <= pc_reg`, a don't-care since the output is a bubble.
  - 10/11 → STALL:
    - From a state other than STALL: `hold_inst <= inst` and `hold_valid <= inst_valid` (the current outputs).
    - From STALL: the hold registers keep their value.
    - `inst_pc` is unchanged.
- Consequences:
  - A stall entered from FLUSH or BOOT holds a bubble (`hold_valid=0`).
  - A redirect during STALL goes to FLUSH.
  - Leaving STALL with 00 goes to RUN. `im_do` then carries the read of the held `pc` made in the last stall cycle, so no instruction is lost or duplicated.
- `fetch_cnt`:
  - Increments by 1 on each edge where the next state is RUN.
  - Wraps 0xFFFF→0x0000.
  - Unaffected by STALL or FLUSH.
- `pc_reg` saturation at 2048 needs no special handling. The same address is refetched and delivered each cycle as a valid instruction, and `fetch_cnt` keeps counting.

## Timing
- Reset (async, `rst_n=0`):
  - `state=BOOT`, `hold_inst=NOP`, `hold_valid=0`, `inst_pc=0`, `fetch_cnt=0`.
  - Outputs: `inst=NOP`, `inst_valid=0`, `im_ceb=1`, `im_a=pc`.
- Fetch latency: the instruction for `pc` sampled at edge k appears on `inst` during cycle k+1, combinationally from `im_do`, with `inst_pc` registered alongside it.
- Redirect (`pc_sel=01` in cycle t):
  - Cycle t+1 shows a bubble.
  - Cycle t+2 shows the target instruction, provided `pc_sel=00` in cycle t+1.
  - Exactly one bubble per redirect.
- Stall:
  - `inst`, `inst_valid` and `inst_pc` are bit-identical on every stall cycle to their values in the cycle before the stall began.
- Reset asserted mid-operation: all state returns to reset values immediately, with no clock required. The first post-reset cycle is BOOT, then RUN.

## Test plan
- Reset release, `pc_sel=00`, SRAM preloaded with M[i]=0x1000_0000+i, pc_reg 0,4,8…: cycle 1 `inst_valid=0`; cycles 2..6 `inst`=0x1000_0000..0x1000_0004, `inst_pc`=0..16; `fetch_cnt`=5.
- Stall 3 cycles while `inst`=0x1000_0002: `inst` stays 0x1000_0002, `inst_valid=1`, `inst_pc=8`, `fetch_cnt` frozen. After release the next `inst` is 0x1000_0003, with no skip or duplicate.
- Redirect in cycle t with target pc_reg=0x40: cycle t+1 `inst=0x13`, `inst_valid=0`; cycle t+2 `inst=M[16]`, `inst_pc=0x40`.
- Stall on the FLUSH cycle for 2 cycles: bubble held (`inst_valid=0`, `inst=0x13`). Then `pc_sel=00` delivers the target instruction once.
- Force `fetch_cnt`=0xFFFE and run 3 sequential fetches: the count reads 0xFFFF, 0x0000, 0x0001.
- Assert `rst_n` low mid-stall between clock edges: outputs go immediately to NOP / `inst_valid=0` / `inst_pc=0` / `fetch_cnt=0`, and the sequence restarts from BOOT.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
// instr_fetch_unit
// Fetch stage that sits next to the PC block. It drives a 1-cycle-latency
// synchronous instruction SRAM from the PC block's word address, and hands the
// returned word, its byte PC and a valid flag to decode. Stalls replay the
// held instruction, redirects insert exactly one bubble, and every newly
// delivered valid instruction bumps a 16-bit wrapping fetch counter.

module instr_fetch_unit #(
  parameter logic [31:0] NOP = 32'h0000_0013,  // addi x0,x0,0 used for bubbles
  parameter int          AW  = 14               // SRAM word-address width
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    pc_sel,
  input  logic [AW-1:0] pc,
  input  logic [31:0]   pc_reg,
  output logic          im_ceb,
  output logic [AW-1:0] im_a,
  input  logic [31:0]   im_do,
  output logic [31:0]   inst,
  output logic          inst_valid,
  output logic [31:0]   inst_pc,
  output logic [15:0]   fetch_cnt
);

  // Legacy-compatible state encoding.
  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_REDIR  = 2'b01;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] hold_inst;
  logic        hold_valid;

  // The SRAM is read every cycle out of reset, including stalls; during a
  // stall the PC block holds pc, so the last stall cycle re-reads the word
  // that must be delivered when the stall releases.
  assign im_a   = pc;
  assign im_ceb = ~rst_n;

  // Next state depends only on pc_sel; the rule is the same from every state.
  always_comb begin
    // NOTE: assign a default first so no path through the case leaves
    // state_nxt unassigned, which would otherwise infer a latch.
    state_nxt = STALL;
    case (pc_sel)
      SEL_SEQ:   state_nxt = RUN;
      SEL_REDIR: state_nxt = FLUSH;
      default:   state_nxt = STALL;   // 10 and 11 both hold
    endcase
  end

  // Decode-facing instruction and valid flag, selected by the current state.
  always_comb begin
    inst       = NOP;
    inst_valid = 1'b0;
    case (state)
      RUN: begin
        inst       = im_do;
        inst_valid = 1'b1;
      end
      STALL: begin
        inst       = hold_inst;
        inst_valid = hold_valid;
      end
      default: begin              // BOOT and FLUSH present a bubble
        inst       = NOP;
        inst_valid = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture what decode sees on the first stall cycle; keep it while stalled.
  // Entering from BOOT or FLUSH captures a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_inst  <= NOP;
      hold_valid <= 1'b0;
    end else if (state_nxt == STALL && state != STALL) begin
      hold_inst  <= inst;
      hold_valid <= inst_valid;
    end
  end

  // Byte PC travelling with the instruction; frozen across stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_pc <= 32'd0;
    end else if (state_nxt != STALL) begin
      inst_pc <= pc_reg;
    end
  end

  // Count each edge that delivers a fresh instruction; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 16'd0;
    end else if (state_nxt == RUN) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
// Testbench for instr_fetch_unit: models the PC block and a 1-cycle-latency
// SRAM holding M[i] = 0x1000_0000 + i, then applies a table of pc_sel steps
// with hand-computed expectations plus counter-wrap and mid-stall reset runs.

module tb_instr_fetch_unit;

  localparam int          AW    = 14;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic          clk;
  logic          rst_n;
  logic [1:0]    pc_sel;
  logic [AW-1:0] pc;
  logic [31:0]   pc_reg;
  logic          im_ceb;
  logic [AW-1:0] im_a;
  logic [31:0]   im_do;
  logic [31:0]   inst;
  logic          inst_valid;
  logic [31:0]   inst_pc;
  logic [15:0]   fetch_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  instr_fetch_unit #(.NOP(NOP_W), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_sel     (pc_sel),
    .pc         (pc),
    .pc_reg     (pc_reg),
    .im_ceb     (im_ceb),
    .im_a       (im_a),
    .im_do      (im_do),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_pc    (inst_pc),
    .fetch_cnt  (fetch_cnt)
  );

  assign pc = pc_reg[15:2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (!im_ceb) im_do <= mem[im_a];
  end

  function automatic logic [31:0] mem_word(input logic [AW-1:0] idx);
    return 32'h1000_0000 + {{(32-AW){1'b0}}, idx};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock with pc_sel applied; afterwards the PC block model updates
  // pc_reg and outputs for the new cycle are stable.
  task automatic cyc(input logic [1:0] sel, input logic [31:0] tgt);
    pc_sel = sel;
    @(posedge clk);
    #1;
    case (sel)
      2'b00:   pc_reg = pc_reg + 32'd4;
      2'b01:   pc_reg = tgt;
      default: pc_reg = pc_reg;
    endcase
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic        exp_v;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  initial begin
    logic [31:0] exp_w;
    logic [31:0] exp_p;
    logic [15:0] exp_c;

    for (int i = 0; i < (1 << AW); i++) mem[i] = mem_word(i[AW-1:0]);

    // sel,   tgt,          v,    inst,          inst_pc,    cnt
    vecs[0]  = '{2'b00, 32'h0,   1'b1, mem_word(0),  32'd0,    16'd1};
    vecs[1]  = '{2'b00, 32'h0,   1'b1, mem_word(1),  32'd4,    16'd2};
    vecs[2]  = '{2'b00, 32'h0,   1'b1, mem_word(2),  32'd8,    16'd3};
    vecs[3]  = '{2'b00, 32'h0,   1'b1, mem_word(3),  32'd12,   16'd4};
    vecs[4]  = '{2'b00, 32'h0,   1'b1, mem_word(4),  32'd16,   16'd5};
    vecs[5]  = '{2'b01, 32'h8,   1'b0, NOP_W,        32'd20,   16'd5};   // redirect to 0x8
    vecs[6]  = '{2'b00, 32'h0,   1'b1, mem_word(2),  32'd8,    16'd6};
    vecs[7]  = '{2'b10, 32'h0,   1'b1, mem_word(2),  32'd8,    16'd6};   // stall x3
    vecs[8]  = '{2'b10, 32'h0,   1'b1, mem_word(2),  32'd8,    16'd6};
    vecs[9]  = '{2'b10, 32'h0,   1'b1, mem_word(2),  32'd8,    16'd6};
    vecs[10] = '{2'b00, 32'h0,   1'b1, mem_word(3),  32'd12,   16'd7};   // no skip/dup
    vecs[11] = '{2'b01, 32'h40,  1'b0, NOP_W,        32'd16,   16'd7};   // redirect to 0x40
    vecs[12] = '{2'b00, 32'h0,   1'b1, mem_word(16), 32'h40,   16'd8};
    vecs[13] = '{2'b01, 32'h80,  1'b0, NOP_W,        32'h44,   16'd8};   // redirect to 0x80
    vecs[14] = '{2'b10, 32'h0,   1'b0, NOP_W,        32'h44,   16'd8};   // stall on flush
    vecs[15] = '{2'b10, 32'h0,   1'b0, NOP_W,        32'h44,   16'd8};
    vecs[16] = '{2'b00, 32'h0,   1'b1, mem_word(32), 32'h80,   16'd9};
    vecs[17] = '{2'b00, 32'h0,   1'b1, mem_word(33), 32'h84,   16'd10};
    vecs[18] = '{2'b10, 32'h0,   1'b1, mem_word(33), 32'h84,   16'd10};
    vecs[19] = '{2'b01, 32'h100, 1'b0, NOP_W,        32'h88,   16'd10};  // redirect in stall
    vecs[20] = '{2'b00, 32'h0,   1'b1, mem_word(64), 32'h100,  16'd11};
    vecs[21] = '{2'b11, 32'h0,   1'b1, mem_word(64), 32'h100,  16'd11};  // 11 holds
    vecs[22] = '{2'b00, 32'h0,   1'b1, mem_word(65), 32'h104,  16'd12};

    // Reset state.
    rst_n  = 1'b0;
    pc_sel = 2'b00;
    pc_reg = 32'd0;
    #12;
    check("reset inst",       inst,                 NOP_W);
    check("reset inst_valid", {31'd0, inst_valid},  32'd0);
    check("reset inst_pc",    inst_pc,              32'd0);
    check("reset fetch_cnt",  {16'd0, fetch_cnt},   32'd0);
    check("reset im_ceb",     {31'd0, im_ceb},      32'd1);
    check("reset im_a",       {18'd0, im_a},        32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("boot inst_valid", {31'd0, inst_valid}, 32'd0);
    check("boot inst",       inst,                NOP_W);
    check("boot im_ceb",     {31'd0, im_ceb},     32'd0);

    // Table-driven sequence.
    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].sel, vecs[i].tgt);
      check($sformatf("vec%0d inst_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].exp_v});
      check($sformatf("vec%0d inst", i),       inst,                 vecs[i].exp_inst);
      check($sformatf("vec%0d inst_pc", i),    inst_pc,              vecs[i].exp_pc);
      check($sformatf("vec%0d fetch_cnt", i),  {16'd0, fetch_cnt},   {16'd0, vecs[i].exp_cnt});
      check($sformatf("vec%0d im_a", i),       {18'd0, im_a},        {18'd0, pc_reg[15:2]});
    end

    // Run the counter up to 0xFFFE, then watch it wrap.
    for (int i = 0; i < 16'hFFFE - 12; i++) cyc(2'b00, 32'h0);
    check("pre-wrap fetch_cnt", {16'd0, fetch_cnt}, 32'h0000_FFFE);
    exp_c = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      exp_w = mem_word(pc_reg[15:2]);
      exp_p = pc_reg;
      exp_c = exp_c + 16'd1;
      cyc(2'b00, 32'h0);
      check($sformatf("wrap%0d fetch_cnt", i), {16'd0, fetch_cnt}, {16'd0, exp_c});
      check($sformatf("wrap%0d inst", i),      inst,               exp_w);
      check($sformatf("wrap%0d inst_pc", i),   inst_pc,            exp_p);
    end

    // Asynchronous reset asserted between edges while stalled.
    cyc(2'b10, 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst inst",       inst,                NOP_W);
    check("midrst inst_valid", {31'd0, inst_valid}, 32'd0);
    check("midrst inst_pc",    inst_pc,             32'd0);
    check("midrst fetch_cnt",  {16'd0, fetch_cnt},  32'd0);
    check("midrst im_ceb",     {31'd0, im_ceb},     32'd1);
    pc_reg = 32'd0;
    pc_sel = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reboot inst_valid", {31'd0, inst_valid}, 32'd0);
    cyc(2'b00, 32'h0);
    check("reboot inst",       inst,                mem_word(0));
    check("reboot inst_valid", {31'd0, inst_valid}, 32'd1);
    check("reboot inst_pc",    inst_pc,             32'd0);
    check("reboot fetch_cnt",  {16'd0, fetch_cnt},  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
